// File: rtl/arm_fetch_stage_pkg.sv
// arm_fetch_stage_pkg: shared fetch defaults, word size and buffer entry layout {pc, instr}.
package arm_fetch_stage_pkg;
    localparam int ADDR_W_DEF = 32;
    localparam int DATA_W_DEF = 32;
    localparam int FIFO_DEPTH_DEF = 4;
    localparam int WORD_BYTES = 4;
    localparam logic [31:0] RESET_PC_DEF = 32'h0;
    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] instr;
    } fetch_entry_t;
    function automatic int entry_w(int aw, int dw);
        return aw + dw;
    endfunction
endpackage

// File: rtl/arm_fetch_stage_if.sv
// arm_fetch_stage_if: imem request/response, redirect and decode handshake bundle.
interface arm_fetch_stage_if
    import arm_fetch_stage_pkg::*;
#(
    parameter int ADDR_W = ADDR_W_DEF,
    parameter int DATA_W = DATA_W_DEF
) ();
    logic              imem_req;
    logic [ADDR_W-1:0] imem_addr;
    logic              imem_gnt;
    logic              imem_rvalid;
    logic [DATA_W-1:0] imem_rdata;
    logic              redirect_valid;
    logic [ADDR_W-1:0] redirect_pc;
    logic              if_valid;
    logic              if_ready;
    logic [DATA_W-1:0] if_instr;
    logic [ADDR_W-1:0] if_pc;
    modport master (
        output imem_req, imem_addr, if_valid, if_instr, if_pc,
        input  imem_gnt, imem_rvalid, imem_rdata, redirect_valid, redirect_pc, if_ready
    );
    modport slave (
        input  imem_req, imem_addr, if_valid, if_instr, if_pc,
        output imem_gnt, imem_rvalid, imem_rdata, redirect_valid, redirect_pc, if_ready
    );
endinterface

// File: rtl/arm_fetch_stage_fetch_fifo.sv
// fetch_fifo: parametric sync FIFO with registered storage, zero-latency head and flush.
module fetch_fifo #(
    parameter int DEPTH = 4,
    parameter int WIDTH = 32
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     push_i,
    input  logic                     pop_i,
    input  logic                     flush_i,
    input  logic [WIDTH-1:0]         data_i,
    output logic [WIDTH-1:0]         data_o,
    output logic                     full_o,
    output logic                     empty_o,
    output logic [$clog2(DEPTH):0]   count_o
);
    localparam int AW = $clog2(DEPTH);
    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [AW-1:0] wr_q, rd_q;
    logic [AW:0] cnt_q;
    logic do_push, do_pop;
    assign empty_o = cnt_q == '0;
    assign full_o = cnt_q == (AW+1)'(DEPTH);
    assign count_o = cnt_q;
    assign do_pop = pop_i && !empty_o;
    assign do_push = push_i && (!full_o || do_pop);
    // Head is gated so an empty FIFO always presents zero.
    assign data_o = empty_o ? '0 : mem_q[rd_q];
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_q <= '0;
            rd_q <= '0;
            cnt_q <= '0;
        end else if (flush_i) begin
            wr_q <= '0;
            rd_q <= '0;
            cnt_q <= '0;
        end else begin
            wr_q <= wr_q + AW'(do_push);
            rd_q <= rd_q + AW'(do_pop);
            cnt_q <= cnt_q + (AW+1)'(do_push) - (AW+1)'(do_pop);
        end
    end
    always_ff @(posedge clk) begin
        if (do_push && !flush_i) mem_q[wr_q] <= data_i;
    end
    assert property (@(posedge clk) disable iff (!rst_n) !(push_i && full_o && !pop_i && !flush_i));
endmodule

// File: rtl/arm_fetch_stage.sv
// arm_fetch_stage: owns the PC, issues credit-limited imem fetches and buffers words for decode.
// Defining FETCH_PERF_CNT_EN adds saturating bubble and flush counters.
module arm_fetch_stage
    import arm_fetch_stage_pkg::*;
#(
    parameter int ADDR_W = ADDR_W_DEF,
    parameter int DATA_W = DATA_W_DEF,
    parameter int FIFO_DEPTH = FIFO_DEPTH_DEF,
    parameter logic [ADDR_W-1:0] RESET_PC = ADDR_W'(RESET_PC_DEF)
) (
    input logic clk,
    input logic rst_n,
    arm_fetch_stage_if.master bus
`ifdef FETCH_PERF_CNT_EN
    ,
    output logic [31:0] perf_bubble_cnt_o,
    output logic [31:0] perf_flush_cnt_o
`endif
);
    localparam int CW = $clog2(FIFO_DEPTH) + 1;
    localparam int EW = entry_w(ADDR_W, DATA_W);
    logic [ADDR_W-1:0] pc_q, pc_d, aq_head;
    logic [CW-1:0] drop_q, drop_d, occ, aq_cnt;
    logic [CW+1:0] used;
    logic [EW-1:0] head;
    logic started_q, redir, hs, resp, pop;
    logic ib_full, ib_empty, aq_full, aq_empty;
    assign redir = bus.redirect_valid;
    // Dropped responses still hold a credit until they come back.
    assign used = (CW+2)'(occ) + (CW+2)'(aq_cnt) + (CW+2)'(drop_q);
    assign bus.imem_req = started_q && !redir && used < (CW+2)'(FIFO_DEPTH);
    assign bus.imem_addr = pc_q;
    assign hs = bus.imem_req && bus.imem_gnt;
    assign resp = bus.imem_rvalid && drop_q == '0;
    assign bus.if_valid = !ib_empty;
    assign pop = bus.if_valid && bus.if_ready;
    assign {bus.if_pc, bus.if_instr} = head;
    always_comb begin
        pc_d = redir ? (bus.redirect_pc & ~ADDR_W'(3)) : hs ? pc_q + ADDR_W'(WORD_BYTES) : pc_q;
        drop_d = redir ? drop_q + aq_cnt - CW'(bus.imem_rvalid) + CW'(hs) :
                 (bus.imem_rvalid && drop_q != '0) ? drop_q - CW'(1) : drop_q;
    end
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pc_q <= RESET_PC;
            drop_q <= '0;
            started_q <= 1'b0;
        end else begin
            pc_q <= pc_d;
            drop_q <= drop_d;
            started_q <= 1'b1;
        end
    end
    fetch_fifo #(.DEPTH(FIFO_DEPTH), .WIDTH(ADDR_W)) u_addr_q (
        .clk(clk), .rst_n(rst_n), .push_i(hs), .pop_i(resp), .flush_i(redir),
        .data_i(pc_q), .data_o(aq_head), .full_o(aq_full), .empty_o(aq_empty), .count_o(aq_cnt)
    );
    fetch_fifo #(.DEPTH(FIFO_DEPTH), .WIDTH(EW)) u_ibuf (
        .clk(clk), .rst_n(rst_n), .push_i(resp), .pop_i(pop), .flush_i(redir),
        .data_i({aq_head, bus.imem_rdata}), .data_o(head), .full_o(ib_full), .empty_o(ib_empty),
        .count_o(occ)
    );
    assert property (@(posedge clk) disable iff (!rst_n) !(hs && aq_full));
    assert property (@(posedge clk) disable iff (!rst_n) !(resp && aq_empty));
    assert property (@(posedge clk) disable iff (!rst_n) !(resp && ib_full && !pop && !redir));
`ifdef FETCH_PERF_CNT_EN
    logic [31:0] bubble_q, flush_q;
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            bubble_q <= '0;
            flush_q <= '0;
        end else begin
            if (bus.if_ready && !bus.if_valid && bubble_q != '1) bubble_q <= bubble_q + 32'd1;
            if (redir && flush_q != '1) flush_q <= flush_q + 32'd1;
        end
    end
    assign perf_bubble_cnt_o = bubble_q;
    assign perf_flush_cnt_o = flush_q;
`endif
endmodule

// File: tb/tb_arm_fetch_stage.sv
// tb_arm_fetch_stage: randomized imem/decode environment with a transaction-level scoreboard.
module tb_arm_fetch_stage;
    import arm_fetch_stage_pkg::*;
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;
    arm_fetch_stage_if #(.ADDR_W(32), .DATA_W(32)) bus ();
`ifdef FETCH_PERF_CNT_EN
    logic [31:0] bub, flc;
`endif
    arm_fetch_stage #(.ADDR_W(32), .DATA_W(32), .FIFO_DEPTH(4), .RESET_PC(32'h0)) dut (
        .clk(clk), .rst_n(rst_n), .bus(bus)
`ifdef FETCH_PERF_CNT_EN
        , .perf_bubble_cnt_o(bub), .perf_flush_cnt_o(flc)
`endif
    );
    typedef struct {
        logic [31:0] addr;
        int epoch;
        int due;
    } req_t;
    req_t mq[$];
    logic [31:0] exp_q[$];
    logic [31:0] popped[$];
    logic [31:0] fpc;
    int cyc = 0, epoch = 0, hs_cnt = 0;
    int vectors = 0, errors = 0;
    int gnt_pct = 100, rdy_pct = 100, lat_min = 1, lat_max = 1;
    longint bubbles = 0, flushes = 0;

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return (a * 32'h9E3779B1) ^ 32'h5A5A0F0F;
    endfunction

    // One clock: drive at negedge, check against the model, then advance the model to the edge.
    task automatic step(input bit redir, input logic [31:0] tgt, input bit cond, output bit fired);
        bit rv, g, rd, exp_req;
        req_t h;
        int lat;
        @(negedge clk);
        cyc++;
        rv = mq.size() > 0 && mq[0].due <= cyc;
        g = $urandom_range(99) < gnt_pct;
        rd = cond ? 1'b1 : ($urandom_range(99) < rdy_pct);
        fired = redir && (!cond || (rv && exp_q.size() > 0));
        bus.imem_gnt = g;
        bus.imem_rvalid = rv;
        bus.imem_rdata = rv ? mem_word(mq[0].addr) : $urandom;
        bus.redirect_valid = fired;
        bus.redirect_pc = tgt;
        bus.if_ready = rd;
        #1;
        exp_req = !fired && (exp_q.size() + mq.size()) < 4;
        vectors++;
        if (bus.imem_req !== exp_req) begin
            errors++;
            $display("FAIL req cyc=%0d got=%b exp=%b", cyc, bus.imem_req, exp_req);
        end
        if (exp_req) begin
            vectors++;
            if (bus.imem_addr !== fpc) begin
                errors++;
                $display("FAIL addr cyc=%0d got=%h exp=%h", cyc, bus.imem_addr, fpc);
            end
        end
        vectors++;
        if (bus.if_valid !== (exp_q.size() > 0)) begin
            errors++;
            $display("FAIL if_valid cyc=%0d got=%b exp=%b", cyc, bus.if_valid, exp_q.size() > 0);
        end
        if (exp_q.size() > 0) begin
            vectors++;
            if (bus.if_pc !== exp_q[0] || bus.if_instr !== mem_word(exp_q[0])) begin
                errors++;
                $display("FAIL head cyc=%0d got pc=%h instr=%h exp pc=%h instr=%h", cyc, bus.if_pc,
                         bus.if_instr, exp_q[0], mem_word(exp_q[0]));
            end
        end
`ifdef FETCH_PERF_CNT_EN
        vectors++;
        if (bub !== bubbles[31:0] || flc !== flushes[31:0]) begin
            errors++;
            $display("FAIL perf cyc=%0d got bub=%0d fl=%0d exp bub=%0d fl=%0d", cyc, bub, flc,
                     bubbles, flushes);
        end
`endif
        if (rd && exp_q.size() == 0) bubbles++;
        if (fired) begin
            flushes++;
            epoch++;
            exp_q.delete();
            fpc = tgt & ~32'd3;
        end else if (rd && exp_q.size() > 0) popped.push_back(exp_q.pop_front());
        if (rv) begin
            h = mq.pop_front();
            if (h.epoch == epoch) exp_q.push_back(h.addr);
        end
        if (bus.imem_req && g) begin
            lat = int'($urandom_range(lat_max, lat_min));
            mq.push_back('{addr: bus.imem_addr, epoch: epoch, due: cyc + lat});
            fpc = fpc + 32'd4;
            hs_cnt++;
        end
    endtask

    task automatic run(input int n);
        bit f;
        for (int i = 0; i < n; i++) step(1'b0, 32'h0, 1'b0, f);
    endtask

    task automatic check_idle_after_redirect(input string name);
        @(posedge clk);
        #1;
        vectors++;
        if (bus.if_valid !== 1'b0) begin
            errors++;
            $display("FAIL %s if_valid after redirect got=%b exp=0", name, bus.if_valid);
        end
    endtask

    task automatic test_reset();
        @(negedge clk);
        #2;
        rst_n = 1'b0;
        bus.imem_gnt = 1'b0;
        bus.imem_rvalid = 1'b0;
        bus.imem_rdata = '0;
        bus.redirect_valid = 1'b0;
        bus.redirect_pc = '0;
        bus.if_ready = 1'b0;
        #1;
        vectors++;
        if (bus.imem_req !== 1'b0 || bus.if_valid !== 1'b0 || bus.imem_addr !== 32'h0 ||
            bus.if_instr !== 32'h0 || bus.if_pc !== 32'h0) begin
            errors++;
            $display("FAIL reset outputs got req=%b v=%b addr=%h instr=%h pc=%h exp all zero",
                     bus.imem_req, bus.if_valid, bus.imem_addr, bus.if_instr, bus.if_pc);
        end
`ifdef FETCH_PERF_CNT_EN
        vectors++;
        if (bub !== 32'd0 || flc !== 32'd0) begin
            errors++;
            $display("FAIL reset perf got bub=%0d fl=%0d exp 0 0", bub, flc);
        end
`endif
        mq.delete();
        exp_q.delete();
        popped.delete();
        fpc = 32'h0;
        epoch++;
        bubbles = 0;
        flushes = 0;
        hs_cnt = 0;
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        vectors++;
        if (bus.imem_req !== 1'b0) begin
            errors++;
            $display("FAIL req before first edge got=%b exp=0", bus.imem_req);
        end
    endtask

    task automatic test_sequential();
        gnt_pct = 100; rdy_pct = 100; lat_min = 1; lat_max = 1;
        test_reset();
        run(12);
        vectors++;
        if (popped.size() < 4 || popped[0] !== 32'h0 || popped[1] !== 32'h4 ||
            popped[2] !== 32'h8 || popped[3] !== 32'hC) begin
            errors++;
            $display("FAIL seq_order got n=%0d first=%h exp 0,4,8,C", popped.size(),
                     popped.size() > 0 ? popped[0] : 32'hx);
        end
    endtask

    task automatic test_stall();
        gnt_pct = 100; rdy_pct = 0; lat_min = 1; lat_max = 1;
        test_reset();
        run(20);
        vectors++;
        if (hs_cnt !== 4 || bus.imem_req !== 1'b0 || bus.if_pc !== 32'h0) begin
            errors++;
            $display("FAIL stall got grants=%0d req=%b head=%h exp 4 0 0", hs_cnt, bus.imem_req,
                     bus.if_pc);
        end
        rdy_pct = 100;
        run(12);
        vectors++;
        if (popped.size() < 5 || popped[0] !== 32'h0 || popped[3] !== 32'hC ||
            popped[4] !== 32'h10) begin
            errors++;
            $display("FAIL stall_drain got n=%0d exp 0..0x10 in order", popped.size());
        end
    endtask

    task automatic test_redirect_inflight();
        bit f;
        int n;
        gnt_pct = 100; rdy_pct = 100; lat_min = 3; lat_max = 3;
        test_reset();
        n = 0;
        while (mq.size() < 2 && n < 20) begin
            step(1'b0, 32'h0, 1'b0, f);
            n++;
        end
        vectors++;
        if (mq.size() < 2) begin
            errors++;
            $display("FAIL redirect_setup inflight got=%0d exp>=2", mq.size());
        end
        step(1'b1, 32'h103, 1'b0, f);
        check_idle_after_redirect("redirect_inflight");
        popped.delete();
        run(15);
        vectors++;
        if (popped.size() < 1 || popped[0] !== 32'h100) begin
            errors++;
            $display("FAIL redirect_target got n=%0d first=%h exp 100", popped.size(),
                     popped.size() > 0 ? popped[0] : 32'hx);
        end
    endtask

    task automatic test_redirect_pop();
        bit f;
        int n;
        gnt_pct = 100; rdy_pct = 100; lat_min = 1; lat_max = 1;
        test_reset();
        run(4);
        f = 1'b0;
        n = 0;
        while (!f && n < 30) begin
            step(1'b1, 32'h200, 1'b1, f);
            n++;
        end
        vectors++;
        if (!f) begin
            errors++;
            $display("FAIL redirect_pop fired got=0 exp=1");
        end
        check_idle_after_redirect("redirect_pop");
        popped.delete();
        run(10);
        vectors++;
        if (popped.size() < 1 || popped[0] !== 32'h200) begin
            errors++;
            $display("FAIL redirect_pop target got n=%0d exp first 200", popped.size());
        end
    endtask

    task automatic test_wrap();
        bit f;
        gnt_pct = 100; rdy_pct = 100; lat_min = 1; lat_max = 2;
        run(3);
        step(1'b1, 32'hFFFFFFFE, 1'b0, f);
        popped.delete();
        run(10);
        vectors++;
        if (popped.size() < 2 || popped[0] !== 32'hFFFFFFFC || popped[1] !== 32'h0) begin
            errors++;
            $display("FAIL wrap got n=%0d exp FFFFFFFC then 0", popped.size());
        end
    endtask

    task automatic test_random();
        bit f;
        gnt_pct = 60; rdy_pct = 70; lat_min = 1; lat_max = 4;
        for (int i = 0; i < 500; i++)
            step($urandom_range(99) < 4, $urandom, 1'b0, f);
    endtask

    task automatic test_back_to_back();
        bit f;
        gnt_pct = 100; rdy_pct = 100; lat_min = 2; lat_max = 4;
        run(5);
        step(1'b1, 32'h400, 1'b0, f);
        step(1'b1, 32'h800, 1'b0, f);
        popped.delete();
        run(12);
        vectors++;
        if (popped.size() < 1 || popped[0] !== 32'h800) begin
            errors++;
            $display("FAIL back_to_back got n=%0d exp first 800", popped.size());
        end
    endtask

    task automatic test_reset_mid();
        gnt_pct = 80; rdy_pct = 60; lat_min = 1; lat_max = 3;
        run(15);
        test_reset();
        run(30);
    endtask

    initial begin
        test_reset();
        test_sequential();
        test_stall();
        test_redirect_inflight();
        test_redirect_pop();
        test_wrap();
        test_back_to_back();
        test_random();
        test_reset_mid();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end
endmodule
